// File: rtl/alarm_pkg.sv
// Shared types, blank code and 24-hour digit limits for HH:MM keypad entry.
package alarm_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  localparam logic [3:0]  BLANK_DIGIT      = 4'ha;
  localparam logic [15:0] BLANK_WORD       = 16'haaaa;
  localparam logic [3:0]  MAX_H_TENS       = 4'd2;
  localparam logic [3:0]  MAX_H_UNITS_AT_2 = 4'd3;
  localparam logic [3:0]  MAX_M_TENS       = 4'd5;
  localparam logic [3:0]  MAX_DIGIT        = 4'd9;

  // Position-dependent legality of digit d; first is the hours-tens digit already stored.
  function automatic logic digit_legal(input logic [1:0] pos, input logic [3:0] first,
                                       input logic [3:0] d);
    logic ok;
    case (pos)
      2'd0:    ok = (d <= MAX_H_TENS);
      2'd1:    ok = (first == MAX_H_TENS) ? (d <= MAX_H_UNITS_AT_2) : (d <= MAX_DIGIT);
      2'd2:    ok = (d <= MAX_M_TENS);
      default: ok = (d <= MAX_DIGIT);
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/entry_timer.sv
// Idle timeout counter for keypad entry; only instantiated when KEYPAD_TIMEOUT_EN is defined.
module entry_timer
  #(parameter int TIMEOUT_CYCLES = 50_000_000)
  (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
  );

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] count_r;

  // Count idle cycles; hold at the terminal value until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable && (count_r != LAST)) begin
      count_r <= count_r + ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = enable && (count_r == LAST);

endmodule

// File: rtl/keypad_entry_ctrl.sv
// HH:MM keypad entry sequencer feeding the time-of-day and alarm registers.
// Optional idle timeout is built when KEYPAD_TIMEOUT_EN is defined.
module keypad_entry_ctrl
  import alarm_pkg::*;
  #(parameter int TIMEOUT_CYCLES = 50_000_000)
  (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        key_valid,
    input  logic [3:0]  key_code,
    input  logic        set_time_req,
    input  logic        set_alarm_req,
    input  logic        cancel,
    output logic [15:0] entry_digits,
    output logic        busy,
    output logic        target_alarm,
    output logic [7:0]  commit_hh,
    output logic [7:0]  commit_mm,
    output logic        load_time,
    output logic        load_alarm,
    output logic        digit_error
  );

  state_t      state_r;
  logic [1:0]  cnt_r;
  logic [15:0] shifted_s;
  logic        timer_expired_s;

  assign shifted_s = {entry_digits[11:0], key_code};

`ifdef KEYPAD_TIMEOUT_EN
  entry_timer #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_entry_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (key_valid || (state_r != COLLECT)),
    .enable  (state_r == COLLECT),
    .expired (timer_expired_s)
  );
`else
  logic unused_timeout_s;
  assign unused_timeout_s = ^TIMEOUT_CYCLES;
  assign timer_expired_s  = 1'b0;
`endif

  // Entry FSM with all outputs registered; strobes default low each cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      cnt_r        <= 2'd0;
      entry_digits <= BLANK_WORD;
      busy         <= 1'b0;
      target_alarm <= 1'b0;
      commit_hh    <= 8'h00;
      commit_mm    <= 8'h00;
      load_time    <= 1'b0;
      load_alarm   <= 1'b0;
      digit_error  <= 1'b0;
    end else begin
      load_time   <= 1'b0;
      load_alarm  <= 1'b0;
      digit_error <= 1'b0;
      case (state_r)
        IDLE: begin
          entry_digits <= BLANK_WORD;
          cnt_r        <= 2'd0;
          if (set_time_req || set_alarm_req) begin
            state_r      <= COLLECT;
            busy         <= 1'b1;
            target_alarm <= ~set_time_req;
          end else begin
            busy <= 1'b0;
          end
        end
        COLLECT: begin
          if (cancel) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            entry_digits <= BLANK_WORD;
            cnt_r        <= 2'd0;
          end else if (key_valid) begin
            if (key_code == BLANK_DIGIT) begin
              cnt_r <= cnt_r;
            end else if ((key_code > MAX_DIGIT) ||
                         !digit_legal(cnt_r, entry_digits[3:0], key_code)) begin
              digit_error <= 1'b1;
            end else begin
              entry_digits <= shifted_s;
              cnt_r        <= cnt_r + 2'd1;
              // Fourth digit: present the commit in the very next cycle.
              if (cnt_r == 2'd3) begin
                state_r    <= COMMIT;
                commit_hh  <= shifted_s[15:8];
                commit_mm  <= shifted_s[7:0];
                load_time  <= ~target_alarm;
                load_alarm <= target_alarm;
              end else begin
                state_r <= COLLECT;
              end
            end
          end else if (timer_expired_s) begin
            state_r      <= IDLE;
            busy         <= 1'b0;
            entry_digits <= BLANK_WORD;
            cnt_r        <= 2'd0;
            digit_error  <= 1'b1;
          end else begin
            state_r <= COLLECT;
          end
        end
        COMMIT: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          entry_digits <= BLANK_WORD;
          cnt_r        <= 2'd0;
        end
        default: begin
          state_r      <= IDLE;
          busy         <= 1'b0;
          entry_digits <= BLANK_WORD;
          cnt_r        <= 2'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_entry_ctrl.sv
// Directed self-checking bench for keypad_entry_ctrl; the timeout scenario runs when KEYPAD_TIMEOUT_EN is defined.
module tb_keypad_entry_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_code = 4'd10;
  logic        set_time_req = 1'b0;
  logic        set_alarm_req = 1'b0;
  logic        cancel = 1'b0;
  logic [15:0] entry_digits;
  logic        busy;
  logic        target_alarm;
  logic [7:0]  commit_hh;
  logic [7:0]  commit_mm;
  logic        load_time;
  logic        load_alarm;
  logic        digit_error;

  int tests = 0;
  int fails = 0;

  keypad_entry_ctrl #(.TIMEOUT_CYCLES(16)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .key_valid     (key_valid),
    .key_code      (key_code),
    .set_time_req  (set_time_req),
    .set_alarm_req (set_alarm_req),
    .cancel        (cancel),
    .entry_digits  (entry_digits),
    .busy          (busy),
    .target_alarm  (target_alarm),
    .commit_hh     (commit_hh),
    .commit_mm     (commit_mm),
    .load_time     (load_time),
    .load_alarm    (load_alarm),
    .digit_error   (digit_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One-cycle key pulse; returns at the negedge after the sampling edge.
  task automatic key(input logic [3:0] d);
    @(negedge clk);
    key_valid = 1'b1;
    key_code  = d;
    @(negedge clk);
    key_valid = 1'b0;
    key_code  = 4'd10;
  endtask

  task automatic req(input logic t, input logic a);
    @(negedge clk);
    set_time_req  = t;
    set_alarm_req = a;
    @(negedge clk);
    set_time_req  = 1'b0;
    set_alarm_req = 1'b0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
  endtask

  initial begin
    // Reset state
    #12;
    check("rst_digits", entry_digits, 16'haaaa);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_target", {15'd0, target_alarm}, 16'd0);
    check("rst_commit", {commit_hh, commit_mm}, 16'h0000);
    check("rst_strobes", {13'd0, load_time, load_alarm, digit_error}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Key in IDLE is ignored
    key(4'd5);
    check("idle_key_digits", entry_digits, 16'haaaa);
    check("idle_key_busy", {15'd0, busy}, 16'd0);

    // Valid time entry 12:34
    req(1'b1, 1'b0);
    check("t_busy", {15'd0, busy}, 16'd1);
    check("t_target", {15'd0, target_alarm}, 16'd0);
    key(4'd1); check("t_d1", entry_digits, 16'haaa1);
    key(4'd2); check("t_d2", entry_digits, 16'haa12);
    key(4'd3); check("t_d3", entry_digits, 16'ha123);
    check("t_noload", {14'd0, load_time, load_alarm}, 16'd0);
    key(4'd4); check("t_d4", entry_digits, 16'h1234);
    check("t_load", {14'd0, load_time, load_alarm}, 16'b10);
    check("t_commit", {commit_hh, commit_mm}, 16'h1234);
    check("t_busy_commit", {15'd0, busy}, 16'd1);
    idle_cycle();
    check("t_load_once", {14'd0, load_time, load_alarm}, 16'd0);
    check("t_reblank", entry_digits, 16'haaaa);
    check("t_busy_drop", {15'd0, busy}, 16'd0);

    // Alarm entry with out-of-range digits: 2,4x,3,6x,5,9
    req(1'b0, 1'b1);
    check("a_target", {15'd0, target_alarm}, 16'd1);
    key(4'd2); check("a_d1", entry_digits, 16'haaa2);
    check("a_d1_err", {15'd0, digit_error}, 16'd0);
    key(4'd4); check("a_4_err", {15'd0, digit_error}, 16'd1);
    check("a_4_digits", entry_digits, 16'haaa2);
    key(4'd3); check("a_d2", entry_digits, 16'haa23);
    check("a_d2_err", {15'd0, digit_error}, 16'd0);
    key(4'd6); check("a_6_err", {15'd0, digit_error}, 16'd1);
    check("a_6_digits", entry_digits, 16'haa23);
    key(4'd5); check("a_d3", entry_digits, 16'ha235);
    key(4'd9);
    check("a_load", {14'd0, load_time, load_alarm}, 16'b01);
    check("a_commit", {commit_hh, commit_mm}, 16'h2359);
    idle_cycle();
    check("a_done", {15'd0, busy}, 16'd0);

    // Cancel against a key
    req(1'b1, 1'b0);
    key(4'd0); key(4'd7);
    check("c_digits_pre", entry_digits, 16'haa07);
    @(negedge clk);
    key_valid = 1'b1; key_code = 4'd1; cancel = 1'b1;
    @(negedge clk);
    key_valid = 1'b0; key_code = 4'd10; cancel = 1'b0;
    check("c_digits", entry_digits, 16'haaaa);
    check("c_busy", {15'd0, busy}, 16'd0);
    check("c_strobes", {13'd0, load_time, load_alarm, digit_error}, 16'd0);

    // Simultaneous requests, code handling, ignored request in COLLECT
    req(1'b1, 1'b1);
    check("p_target", {15'd0, target_alarm}, 16'd0);
    check("p_busy", {15'd0, busy}, 16'd1);
    key(4'd10); check("k10_err", {15'd0, digit_error}, 16'd0);
    check("k10_digits", entry_digits, 16'haaaa);
    key(4'd12); check("k12_err", {15'd0, digit_error}, 16'd1);
    check("k12_digits", entry_digits, 16'haaaa);
    key(4'd3); check("k3_first_err", {15'd0, digit_error}, 16'd1);
    key(4'd2); check("k2_first", entry_digits, 16'haaa2);
    key(4'd4); check("k24_err", {15'd0, digit_error}, 16'd1);
    key(4'd0); check("k20", entry_digits, 16'haa20);
    req(1'b0, 1'b1);
    check("p_ignored", {15'd0, target_alarm}, 16'd0);
    check("p_still_busy", {15'd0, busy}, 16'd1);
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("p_cancel", {15'd0, busy}, 16'd0);

    // Idle timeout behaviour
    req(1'b1, 1'b0);
    key(4'd1);
`ifdef KEYPAD_TIMEOUT_EN
    for (int i = 0; i < 15; i++) idle_cycle();
    check("to_before", {14'd0, busy, digit_error}, 16'b10);
    idle_cycle();
    check("to_fire", {14'd0, busy, digit_error}, 16'b01);
    check("to_digits", entry_digits, 16'haaaa);
    idle_cycle();
    check("to_err_once", {15'd0, digit_error}, 16'd0);
`else
    for (int i = 0; i < 20; i++) idle_cycle();
    check("nto_busy", {15'd0, busy}, 16'd1);
    check("nto_digits", entry_digits, 16'haaa1);
    @(negedge clk); cancel = 1'b1;
    @(negedge clk); cancel = 1'b0;
    check("nto_cancel", {15'd0, busy}, 16'd0);
`endif

    // Asynchronous reset mid-entry
    req(1'b0, 1'b1);
    key(4'd1); key(4'd2); key(4'd3);
    check("r_pre", entry_digits, 16'ha123);
    #2;
    rst_n = 1'b0;
    #1;
    check("r_digits", entry_digits, 16'haaaa);
    check("r_busy", {15'd0, busy}, 16'd0);
    check("r_target", {15'd0, target_alarm}, 16'd0);
    check("r_commit", {commit_hh, commit_mm}, 16'h0000);
    check("r_strobes", {13'd0, load_time, load_alarm, digit_error}, 16'd0);
    @(negedge clk);
    rst_n = 1'b1;
    key(4'd4);
    check("r_after_key", {14'd0, load_alarm, busy}, 16'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
